// File: rtl/sys_ctrl.sv
// System control: reset stretcher/sequencer, per-channel tick dividers,
// one-shot wait timer and a free-running cycle counter.
module sys_ctrl #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned RST_CYCLES = 8,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_sw_rst,
    output logic                  o_rst_sync_n,
    input  logic [N_CH*DIV_W-1:0] i_div,
    input  logic [N_CH-1:0]       i_ch_en,
    output logic [N_CH-1:0]       o_tick,
    input  logic                  i_wait_start,
    input  logic [31:0]           i_wait_n,
    output logic                  o_wait_busy,
    output logic                  o_wait_done,
    output logic [CNT_W-1:0]      o_cyc_cnt
);

    localparam int unsigned C_W = $clog2(RST_CYCLES) + 1;

    typedef enum logic {ST_ASSERT, ST_RUN} state_t;

    state_t             r_state;
    logic [1:0]         r_sync;
    logic [C_W-1:0]     r_c;
    logic               r_rst_sync_n;
    logic [DIV_W-1:0]   r_t [N_CH];
    logic [N_CH-1:0]    r_tick;
    logic [31:0]        r_rem;
    logic               r_busy;
    logic               r_done;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_srst_n;
    logic               w_active;
    logic [DIV_W-1:0]   w_dm1 [N_CH];

    assign w_srst_n     = r_sync[1];
    // A SwRst edge drops the downstream reset, so everything it gates clears on that same edge.
    assign w_active     = r_rst_sync_n & ~i_sw_rst;
    assign o_rst_sync_n = r_rst_sync_n;
    assign o_tick       = r_tick;
    assign o_wait_busy  = r_busy;
    assign o_wait_done  = r_done;
    assign o_cyc_cnt    = r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
        end
    end

    // Reset sequencer: stretch RST_CYCLES clocks after the synchronized release or a SwRst.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_ASSERT;
            r_c          <= '0;
            r_rst_sync_n <= 1'b0;
        end else begin
            case (r_state)
                ST_ASSERT: begin
                    r_rst_sync_n <= 1'b0;
                    if (i_sw_rst) begin
                        r_c <= '0;
                    end else if (w_srst_n) begin
                        if (r_c == C_W'(RST_CYCLES - 1)) begin
                            r_state      <= ST_RUN;
                            r_rst_sync_n <= 1'b1;
                            r_c          <= '0;
                        end else begin
                            r_c <= r_c + C_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (i_sw_rst) begin
                        r_state      <= ST_ASSERT;
                        r_c          <= '0;
                        r_rst_sync_n <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Terminal count per channel is max(Div,1)-1.
    always_comb begin
        for (int i = 0; i < int'(N_CH); i++) begin
            w_dm1[i] = i_div[i*DIV_W +: DIV_W];
            if (w_dm1[i] != '0) begin
                w_dm1[i] = w_dm1[i] - DIV_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                r_t[i] <= '0;
            end
            r_tick <= '0;
        end else begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if (w_active && i_ch_en[i]) begin
                    if (r_t[i] >= w_dm1[i]) begin
                        r_t[i]    <= '0;
                        r_tick[i] <= 1'b1;
                    end else begin
                        r_t[i]    <= r_t[i] + DIV_W'(1);
                        r_tick[i] <= 1'b0;
                    end
                end else begin
                    r_t[i]    <= '0;
                    r_tick[i] <= 1'b0;
                end
            end
        end
    end

    // One-shot timer; a start while busy reloads the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rem  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (!w_active) begin
            r_rem  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (i_wait_start) begin
            r_rem  <= i_wait_n;
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (r_busy) begin
            if (r_rem == '0) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end else begin
                r_rem  <= r_rem - 32'd1;
                r_done <= 1'b0;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!w_active) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sys_ctrl.sv
// Scoreboard bench for sys_ctrl: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_sys_ctrl;

    localparam int N  = 4;
    localparam int DW = 16;

    localparam int K_RS   = 0;
    localparam int K_TICK = 1;
    localparam int K_BUSY = 2;
    localparam int K_DONE = 3;
    localparam int K_CNT  = 4;
    localparam int K_CNT4 = 5;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            sw_rst;
    logic [N*DW-1:0] div;
    logic [N-1:0]    ch_en;
    logic            wait_start;
    logic [31:0]     wait_n;

    logic            rs_n,  rs_n4;
    logic [N-1:0]    tick,  tick4;
    logic            busy,  busy4;
    logic            done,  done4;
    logic [31:0]     cnt;
    logic [3:0]      cnt4;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t q[$];

    sys_ctrl u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_sw_rst(sw_rst), .o_rst_sync_n(rs_n),
        .i_div(div), .i_ch_en(ch_en), .o_tick(tick),
        .i_wait_start(wait_start), .i_wait_n(wait_n),
        .o_wait_busy(busy), .o_wait_done(done), .o_cyc_cnt(cnt)
    );

    sys_ctrl #(.CNT_W(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sw_rst(sw_rst), .o_rst_sync_n(rs_n4),
        .i_div(div), .i_ch_en(ch_en), .o_tick(tick4),
        .i_wait_start(wait_start), .i_wait_n(wait_n),
        .o_wait_busy(busy4), .o_wait_done(done4), .o_cyc_cnt(cnt4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(int k);
        case (k)
            K_RS:    return "rst_sync_n";
            K_TICK:  return "tick";
            K_BUSY:  return "wait_busy";
            K_DONE:  return "wait_done";
            K_CNT:   return "cyc_cnt";
            default: return "cyc_cnt_w4";
        endcase
    endfunction

    function automatic logic [31:0] actual(int k);
        case (k)
            K_RS:    return 32'(rs_n);
            K_TICK:  return 32'(tick);
            K_BUSY:  return 32'(busy);
            K_DONE:  return 32'(done);
            K_CNT:   return cnt;
            default: return 32'(cnt4);
        endcase
    endfunction

    function automatic void push(int c, int k, logic [31:0] v);
        int   i = 0;
        exp_t e;
        e.cyc = c; e.kind = k; e.val = v;
        while (i < q.size() && q[i].cyc <= c) i++;
        q.insert(i, e);
    endfunction

    function automatic void chk_all0(int c);
        for (int k = K_RS; k <= K_CNT4; k++) push(c, k, 32'd0);
    endfunction

    task automatic wait_to(int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: compare every expectation stamped for the edge just taken.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e   = q.pop_front();
            act = actual(e.kind);
            n_vec++;
            if (e.cyc != cyc || act !== e.val) begin
                n_err++;
                $display("FAIL %s @cyc %0d: got %0h expected %0h (checked at %0d)",
                         kname(e.kind), e.cyc, act, e.val, cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c0, run0, a, b, s, s2, s3, t, w, p, r1, r2;
        logic [3:0] tv;

        rst_n = 1'b0; sw_rst = 1'b0; div = '0; ch_en = '0;
        wait_start = 1'b0; wait_n = '0;

        // Power-on reset, then stretched release.
        for (int c = 1; c <= 3; c++) chk_all0(c);
        wait_to(3);
        rst_n = 1'b1;
        c0   = cyc;
        run0 = c0 + 10;
        push(c0 + 9, K_RS, 0);
        push(run0, K_RS, 1);
        push(run0, K_CNT, 0);
        push(run0 + 1, K_CNT, 1);
        push(run0 + 1, K_TICK, 0);
        push(run0 + 15, K_CNT4, 15);
        push(run0 + 16, K_CNT4, 0);
        push(run0 + 16, K_CNT, 16);
        wait_to(run0 + 2);

        // Four channels, Div = {0,1,3,5}.
        a = cyc;
        ch_en = 4'hF;
        div   = {16'd0, 16'd1, 16'd3, 16'd5};
        for (int k = 1; k <= 15; k++) begin
            tv    = 4'b1100;
            tv[0] = (k % 5 == 0);
            tv[1] = (k % 3 == 0);
            push(a + k, K_TICK, 32'(tv));
        end
        wait_to(a + 15);
        ch_en = 4'h0;
        push(a + 16, K_TICK, 0);
        wait_to(a + 16);

        // Divisor shrinks mid-count: 10 -> 4 at t=7.
        b = cyc;
        ch_en = 4'b0001;
        div   = {16'd0, 16'd0, 16'd0, 16'd10};
        for (int k = 1; k <= 16; k++)
            push(b + k, K_TICK, (k == 8 || k == 12 || k == 16) ? 32'd1 : 32'd0);
        wait_to(b + 7);
        div[15:0] = 16'd4;
        wait_to(b + 16);
        ch_en = 4'h0;
        push(b + 17, K_TICK, 0);
        wait_to(b + 18);

        // Timer, WaitN = 0.
        t = cyc; s = t + 1;
        wait_start = 1'b1; wait_n = 32'd0;
        push(s, K_BUSY, 1); push(s, K_DONE, 0);
        push(s + 1, K_BUSY, 0); push(s + 1, K_DONE, 1);
        push(s + 2, K_DONE, 0);
        wait_to(t + 1);
        wait_start = 1'b0;
        wait_to(s + 3);

        // Timer, WaitN = 5.
        t = cyc; s2 = t + 1;
        wait_start = 1'b1; wait_n = 32'd5;
        for (int k = 0; k <= 5; k++) begin
            push(s2 + k, K_BUSY, 1); push(s2 + k, K_DONE, 0);
        end
        push(s2 + 6, K_BUSY, 0); push(s2 + 6, K_DONE, 1);
        push(s2 + 7, K_DONE, 0);
        wait_to(t + 1);
        wait_start = 1'b0;
        wait_to(s2 + 8);

        // Timer, WaitN = 5 with a restart at start+3.
        t = cyc; s3 = t + 1;
        wait_start = 1'b1; wait_n = 32'd5;
        for (int k = 0; k <= 8; k++) begin
            push(s3 + k, K_BUSY, 1); push(s3 + k, K_DONE, 0);
        end
        push(s3 + 9, K_BUSY, 0); push(s3 + 9, K_DONE, 1);
        push(s3 + 10, K_DONE, 0);
        wait_to(t + 1);
        wait_start = 1'b0;
        wait_to(s3 + 2);
        wait_start = 1'b1;
        wait_to(s3 + 3);
        wait_start = 1'b0;
        wait_to(s3 + 11);

        // SwRst with ticks and timer running.
        w = cyc; s = w + 5;
        ch_en = 4'b0011;
        div   = {16'd0, 16'd0, 16'd3, 16'd5};
        wait_start = 1'b1; wait_n = 32'd20;
        push(w + 3, K_TICK, 32'b0010);
        push(w + 4, K_BUSY, 1);
        push(w + 4, K_CNT, 32'(w + 4 - run0));
        for (int k = 0; k <= 7; k++) push(s + k, K_RS, 0);
        push(s + 8, K_RS, 1);
        for (int k = 0; k <= 8; k++) begin
            push(s + k, K_TICK, 0); push(s + k, K_CNT, 0);
        end
        for (int k = 0; k <= 12; k++) push(s + k, K_BUSY, 0);
        push(s + 9, K_CNT, 1);
        push(s + 9, K_TICK, 0);
        push(s + 10, K_TICK, 0);
        push(s + 11, K_TICK, 32'b0010);
        push(s + 12, K_TICK, 0);
        push(s + 13, K_TICK, 32'b0001);
        push(s + 14, K_TICK, 32'b0010);
        wait_to(w + 1);
        wait_start = 1'b0;
        wait_to(w + 4);
        sw_rst = 1'b1;
        wait_to(w + 5);
        sw_rst = 1'b0;
        wait_to(s + 15);

        // Asynchronous reset mid-timer with ticks enabled.
        p = cyc;
        ch_en = 4'hF;
        wait_start = 1'b1; wait_n = 32'd10;
        push(p + 3, K_BUSY, 1);
        wait_to(p + 1);
        wait_start = 1'b0;
        wait_to(p + 3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        chk_all0(cyc);
        #1;
        n_vec += 6;
        if (rs_n !== 1'b0)   begin n_err++; $display("FAIL async rst_sync_n: got %0h", rs_n); end
        if (tick !== 4'h0)   begin n_err++; $display("FAIL async tick: got %0h", tick); end
        if (busy !== 1'b0)   begin n_err++; $display("FAIL async wait_busy: got %0h", busy); end
        if (done !== 1'b0)   begin n_err++; $display("FAIL async wait_done: got %0h", done); end
        if (cnt !== 32'd0)   begin n_err++; $display("FAIL async cyc_cnt: got %0h", cnt); end
        if (cnt4 !== 4'd0)   begin n_err++; $display("FAIL async cyc_cnt_w4: got %0h", cnt4); end
        wait_to(p + 6);
        rst_n = 1'b1;
        r1 = cyc;
        push(r1 + 5, K_RS, 0);

        // Asynchronous reset again mid-stretch: release restarts the full stretch.
        wait_to(r1 + 5);
        @(posedge clk);
        #2 rst_n = 1'b0;
        chk_all0(cyc);
        #1;
        n_vec += 6;
        if (rs_n4 !== 1'b0)  begin n_err++; $display("FAIL async w4 rst_sync_n: got %0h", rs_n4); end
        if (tick4 !== 4'h0)  begin n_err++; $display("FAIL async w4 tick: got %0h", tick4); end
        if (busy4 !== 1'b0)  begin n_err++; $display("FAIL async w4 wait_busy: got %0h", busy4); end
        if (done4 !== 1'b0)  begin n_err++; $display("FAIL async w4 wait_done: got %0h", done4); end
        if (rs_n !== 1'b0)   begin n_err++; $display("FAIL async2 rst_sync_n: got %0h", rs_n); end
        if (cnt !== 32'd0)   begin n_err++; $display("FAIL async2 cyc_cnt: got %0h", cnt); end
        wait_to(r1 + 7);
        rst_n = 1'b1;
        r2 = cyc;
        push(r2 + 3, K_RS, 0);
        push(r2 + 9, K_RS, 0);
        push(r2 + 10, K_RS, 1);
        push(r2 + 11, K_CNT, 1);
        wait_to(r2 + 13);

        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL %s @cyc %0d: never checked, expected %0h", kname(e.kind), e.cyc, e.val);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        if (n_err == 0) $display("PASS");
        else            $display("FAIL");
        $finish;
    end

endmodule
